// File: rtl/wb_pkg.sv
// Shared constants and types for the writeback unit.
// Imported by the top and the scoreboard.
package wb_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int NREG   = 1 << ADDR_W;

   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_ALU  = 2'd1,
      SRC_LSU  = 2'd2
   } wb_src_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write bit per register.
// A set and a clear of the same bit in one cycle leaves it set.
module wb_scoreboard
   import wb_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              set_en,
   input  logic [ADDR_W-1:0] set_addr,
   input  logic              clr_en,
   input  logic [ADDR_W-1:0] clr_addr,
   output logic [NREG-1:0]   busy
);

   logic [NREG-1:0] busy_nxt;

   // apply clear first so a same-cycle set overrides it
   always_comb begin
      busy_nxt = busy;
      if (clr_en)
         busy_nxt[clr_addr] = 1'b0;
      if (set_en)
         busy_nxt[set_addr] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   // busy vector register
   always_ff @(posedge clk) begin
      if (reset)
         busy <= '0;
      else
         busy <= busy_nxt;
   end

endmodule

// File: rtl/writeback_unit.sv
// Arbitrates ALU and LSU results onto the register file write port
// and tracks pending writes for decode hazard stalls.
module writeback_unit #(
   parameter int DATA_W       = wb_pkg::DATA_W,
   parameter int ADDR_W       = wb_pkg::ADDR_W,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              issue_valid,
   input  logic [ADDR_W-1:0] issue_rd,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [ADDR_W-1:0] alu_rd,
   input  logic [DATA_W-1:0] alu_data,
   input  logic              lsu_valid,
   output logic              lsu_ready,
   input  logic [ADDR_W-1:0] lsu_rd,
   input  logic [DATA_W-1:0] lsu_data,
   output logic              wb_en,
   output logic [ADDR_W-1:0] wb_addr,
   output logic [DATA_W-1:0] wb_data,
   output logic [31:0]       busy
);

   import wb_pkg::*;

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0]  starve_cnt;
   wb_src_t           grant;
   logic              take;
   logic [ADDR_W-1:0] sel_rd;
   logic [DATA_W-1:0] sel_data;
   logic              write;

   // grant: LSU by default, ALU once it has starved long enough
   always_comb begin
      grant = SRC_NONE;
      if (reset)
         grant = SRC_NONE;
      else if (alu_valid && lsu_valid)
         grant = (starve_cnt == LIMIT) ? SRC_ALU : SRC_LSU;
      else if (alu_valid)
         grant = SRC_ALU;
      else if (lsu_valid)
         grant = SRC_LSU;
   end

   assign alu_ready = (grant == SRC_ALU);
   assign lsu_ready = (grant == SRC_LSU);
   assign take      = alu_ready | lsu_ready;
   assign sel_rd    = alu_ready ? alu_rd : lsu_rd;
   assign sel_data  = alu_ready ? alu_data : lsu_data;
   assign write     = take && (sel_rd != '0);

   // count cycles the ALU waits while valid
   always_ff @(posedge clk) begin
      if (reset)
         starve_cnt <= '0;
      else if (!alu_valid || alu_ready)
         starve_cnt <= '0;
      else if (starve_cnt != LIMIT)
         starve_cnt <= starve_cnt + 1'b1;
   end

   // registered write port; address/data hold when idle
   always_ff @(posedge clk) begin
      if (reset) begin
         wb_en   <= 1'b0;
         wb_addr <= '0;
         wb_data <= '0;
      end else begin
         wb_en <= write;
         if (write) begin
            wb_addr <= sel_rd;
            wb_data <= sel_data;
         end
      end
   end

   wb_scoreboard u_sb (
      .clk      (clk),
      .reset    (reset),
      .set_en   (issue_valid && (issue_rd != '0)),
      .set_addr (issue_rd),
      .clr_en   (wb_en),
      .clr_addr (wb_addr),
      .busy     (busy)
   );

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Writer-side front end for the 32 x 32-bit register file. It arbitrates completed results from the ALU and the load/store unit using valid/ready handshakes and drives the register file's synchronous write port from registered outputs. It also keeps a pending-write scoreboard that decode uses to stall on read-after-write hazards. It sits between the execute/memory stages and the register file write port.

## Interface
Parameters:
- DATA_W, 32, result and write-data width
- ADDR_W, 5, register address width (32 registers)
- STARVE_LIMIT, 4, consecutive lost arbitration cycles after which the ALU gets priority (≥1)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- issue_valid  in  1  decode issues an instruction with a destination register
- issue_rd  in  ADDR_W  destination register being issued
- alu_valid  in  1  ALU result available
- alu_ready  out  1  ALU result accepted this cycle (combinational)
- alu_rd  in  ADDR_W  ALU destination
- alu_data  in  DATA_W  ALU result
- lsu_valid  in  1  load result available
- lsu_ready  out  1  load result accepted this cycle (combinational)
- lsu_rd  in  ADDR_W  load destination
- lsu_data  in  DATA_W  load result
- wb_en  out  1  register file write enable (registered)
- wb_addr  out  ADDR_W  register file write address (registered)
- wb_data  out  DATA_W  register file write data (registered)
- busy  out  32  scoreboard; bit i set = write to register i pending

## Operation
- Grant, at most one per cycle:
  - Default: LSU beats ALU.
  - ALU beats LSU when `starve_cnt == STARVE_LIMIT`.
  - A lone valid source is always granted.
- The granted source has `ready = 1`; the other has `ready = 0`. A handshake is `valid && ready`.
- Handshake with `rd != 0`: on the next edge, `wb_en <= 1`, `wb_addr <= rd`, `wb_data <= data`.
- Handshake with `rd == 0`: the result is accepted and dropped. `wb_en` stays 0 and the scoreboard is untouched.
- No handshake: `wb_en <= 0`. `wb_addr` and `wb_data` hold their previous values.
- `starve_cnt`:
  - Increments (saturating at STARVE_LIMIT) when `alu_valid && !alu_ready`.
  - Clears on an ALU handshake or when `!alu_valid`.
- Scoreboard set: `busy[issue_rd]` sets at the edge where `issue_valid && issue_rd != 0`.
- Scoreboard clear: `busy[wb_addr]` clears at the edge ending a cycle with `wb_en = 1`. This is the same edge at which the register file commits the write, so a busy-clear never precedes data visibility.
- Simultaneous set and clear of the same register: set wins, because the register has a new producer.
- `busy[0]` is always 0.
- Producers hold valid, rd and data stable until the handshake. The block does not check this.

## Timing
- Reset values:
  - `wb_en` = 0, `wb_addr` = 0, `wb_data` = 0
  - `busy` = 0, `starve_cnt` = 0
  - `alu_ready` and `lsu_ready` are 0 during the reset cycle.
- Reset mid-operation: any accepted-but-unwritten result is discarded, and `wb_en` is 0 in the cycle after reset.
- Latency: handshake in cycle N gives `wb_en = 1` in cycle N+1. The register is written at the end of N+1, and `busy` drops in cycle N+2.
- Throughput: one write per cycle, with back-to-back grants allowed.
- `ready` depends combinationally on the valids and `starve_cnt` only. There is no path from ready to valid.

## Structure
- Package `wb_pkg`:
  - DATA_W and ADDR_W constants
  - `wb_src_t` enum {SRC_NONE, SRC_ALU, SRC_LSU}, used for the grant and for debug visibility
- Sub-module `wb_scoreboard` holds the 32-bit busy vector with set/clear ports and the set-wins rule.
- Arbitration, the starvation counter and the output register stay in the top level.

## Test plan
1. Reset, then ALU-only stream: `alu_rd = 3, data = 0xDEADBEEF`, handshake in cycle N -> `wb_en = 1, wb_addr = 3, wb_data = 0xDEADBEEF` in N+1; `wb_en = 0` in N+2.
2. Both valid, `lsu_rd = 5 / 0x11`, `alu_rd = 6 / 0x22` -> LSU written first, `alu_ready = 0`; the ALU is written the following cycle.
3. `lsu_valid` held high continuously with a stream of loads, `alu_valid` high, STARVE_LIMIT = 4 -> ALU granted on the 5th cycle (`starve_cnt` reaches 4), then LSU priority resumes.
4. `issue_valid` with `issue_rd = 7` -> `busy[7] = 1` next cycle. ALU writes r7 -> `busy[7]` stays 1 through the `wb_en` cycle and is 0 the cycle after.
5. Same edge: `wb_en` for r9 and `issue_rd = 9` -> `busy[9]` remains 1. `alu_rd = 0` handshake -> `alu_ready = 1`, `wb_en` stays 0, `busy[0] = 0`.
6. Handshake in cycle N with reset asserted in N+1 -> `wb_en = 0` in N+2 and `busy = 0` after reset.
